// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus between the fetch
// stage (master) and instruction memory (slave).
//   imem_req   : request valid, address must stay put until imem_ack
//   imem_addr  : word-aligned fetch address
//   imem_ack   : response valid this cycle (may coincide with the req cycle)
//   imem_rdata : instruction word, meaningful only while imem_ack=1
interface fetch_stage_if #(
  parameter int PCWIDTH = 32,
  parameter int IWIDTH  = 32
);
  logic               imem_req;
  logic [PCWIDTH-1:0] imem_addr;
  logic               imem_ack;
  logic [IWIDTH-1:0]  imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch. Holds the PC, fetches over the imem
// req/ack bus, presents one instruction per cycle to decode, absorbs decode
// back-pressure in a one-entry skid buffer and handles redirects, including
// ones arriving while a memory request is still outstanding.
// Ports:
//   f_clk, f_rst            : clock, async active-low reset
//   f_i_stall               : decode cannot accept, hold outputs
//   f_i_redirect/_pc        : branch/jump taken and its target
//   imem (master)           : instruction memory bus
//   f_o_instr/f_o_pc/f_o_ce : instruction, its address, valid
module fetch_stage #(
  parameter int                 PCWIDTH  = 32,
  parameter int                 IWIDTH   = 32,
  parameter logic [PCWIDTH-1:0] RESET_PC = '0
) (
  input  logic               f_clk,
  input  logic               f_rst,
  input  logic               f_i_stall,
  input  logic               f_i_redirect,
  input  logic [PCWIDTH-1:0] f_i_redirect_pc,
  fetch_stage_if.master      imem,
  output logic [IWIDTH-1:0]  f_o_instr,
  output logic [PCWIDTH-1:0] f_o_pc,
  output logic               f_o_ce
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DISCARD, S_FULL} state_t;

  state_t             r_state, w_nstate;
  logic [PCWIDTH-1:0] r_addr, w_addr;
  logic [PCWIDTH-1:0] r_tgt, w_tgt_n;
  logic [IWIDTH-1:0]  r_skid_instr, w_skid_instr;
  logic [PCWIDTH-1:0] r_skid_pc, w_skid_pc;
  logic [IWIDTH-1:0]  r_instr, w_instr;
  logic [PCWIDTH-1:0] r_pc, w_pc;
  logic               r_ce, w_ce;
  logic               r_req, w_req;
  logic               w_ack;
  logic [PCWIDTH-1:0] w_tgt;
  logic [PCWIDTH-1:0] w_addr_inc;

  // ack only means something while a request is actually out
  assign w_ack      = imem.imem_ack & r_req;
  assign w_tgt      = f_i_redirect_pc & ~PCWIDTH'(3);
  assign w_addr_inc = r_addr + PCWIDTH'(4);

  // state register
  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  // next state
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:    w_nstate = S_FETCH;
      S_FETCH: begin
        if (f_i_redirect)          w_nstate = w_ack ? S_FETCH : S_DISCARD;
        else if (w_ack && f_i_stall) w_nstate = S_FULL;
      end
      S_DISCARD: if (w_ack) w_nstate = S_FETCH;
      S_FULL:    if (f_i_redirect || !f_i_stall) w_nstate = S_FETCH;
      default:   w_nstate = S_IDLE;
    endcase
  end

  // datapath / outputs (registered)
  always_comb begin
    w_addr       = r_addr;
    w_tgt_n      = r_tgt;
    w_skid_instr = r_skid_instr;
    w_skid_pc    = r_skid_pc;
    w_instr      = r_instr;
    w_pc         = r_pc;
    w_ce         = r_ce;
    w_req        = (w_nstate == S_FETCH) || (w_nstate == S_DISCARD);
    case (r_state)
      S_FETCH: begin
        if (f_i_redirect) begin
          w_ce = 1'b0;
          // without ack the old request must finish first; park the target
          if (w_ack) w_addr  = w_tgt;
          else       w_tgt_n = w_tgt;
        end else if (w_ack) begin
          w_addr = w_addr_inc;
          if (!f_i_stall) begin
            w_instr = imem.imem_rdata;
            w_pc    = r_addr;
            w_ce    = 1'b1;
          end else begin
            w_skid_instr = imem.imem_rdata;
            w_skid_pc    = r_addr;
          end
        end else if (!f_i_stall) begin
          w_ce = 1'b0;
        end
      end
      S_DISCARD: begin
        w_ce = 1'b0;
        if (f_i_redirect) w_tgt_n = w_tgt;
        if (w_ack)        w_addr  = f_i_redirect ? w_tgt : r_tgt;
      end
      S_FULL: begin
        if (f_i_redirect) begin
          w_ce   = 1'b0;
          w_addr = w_tgt;
        end else if (!f_i_stall) begin
          w_instr = r_skid_instr;
          w_pc    = r_skid_pc;
          w_ce    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) begin
      r_addr       <= RESET_PC;
      r_tgt        <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_instr      <= '0;
      r_pc         <= '0;
      r_ce         <= 1'b0;
      r_req        <= 1'b0;
    end else begin
      r_addr       <= w_addr;
      r_tgt        <= w_tgt_n;
      r_skid_instr <= w_skid_instr;
      r_skid_pc    <= w_skid_pc;
      r_instr      <= w_instr;
      r_pc         <= w_pc;
      r_ce         <= w_ce;
      r_req        <= w_req;
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign f_o_instr      = r_instr;
  assign f_o_pc         = r_pc;
  assign f_o_ce         = r_ce;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the MIPS pipeline: holds the PC, issues requests to instruction memory over a req/ack handshake, and presents one instruction per cycle to the decode stage. Its outputs drive `decode` directly: `f_o_instr` feeds `d_i_instr` and `f_o_ce` feeds `d_i_ce`. It absorbs back-pressure from decode/hazard logic through a one-entry skid buffer. It handles branch/jump redirects from later stages, including redirects that arrive while a memory request is outstanding.

## Interface
- `PCWIDTH`, 32, PC and memory address width
- `IWIDTH`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- `f_clk`  in  1  clock, all state on rising edge
- `f_rst`  in  1  reset, asynchronous, active-low
- `f_i_stall`  in  1  decode cannot accept; hold outputs
- `f_i_redirect`  in  1  branch/jump taken; refetch from `f_i_redirect_pc`
- `f_i_redirect_pc`  in  PCWIDTH  redirect target; bits [1:0] ignored, forced 0
- `f_o_imem_req`  out  1  request valid (registered)
- `f_o_imem_addr`  out  PCWIDTH  request address; stable while req=1 until ack
- `f_i_imem_ack`  in  1  response valid this cycle; may assert in the same cycle as req
- `f_i_imem_rdata`  in  IWIDTH  instruction word, valid when ack=1
- `f_o_instr`  out  IWIDTH  instruction to decode
- `f_o_pc`  out  PCWIDTH  address of `f_o_instr`
- `f_o_ce`  out  1  `f_o_instr`/`f_o_pc` valid

## Operation
- State machine with states IDLE, FETCH, DISCARD, FULL. `f_o_imem_req`=1 in FETCH and DISCARD only.
- Registers: `addr` (=`f_o_imem_addr`), `tgt`, `skid_instr`, `skid_pc`, and the output registers.
- `f_i_imem_ack` is ignored when req=0.
- IDLE: unconditionally moves to FETCH on the next edge.
- FETCH, priority order:
  - redirect & ack: drop rdata; `addr`<=target; `f_o_ce`<=0; stay in FETCH.
  - redirect & !ack: `tgt`<=target; `f_o_ce`<=0; go to DISCARD. `addr` is unchanged, per the protocol.
  - ack & !stall: outputs<=(rdata, `addr`); `f_o_ce`<=1; `addr`<=`addr`+4.
  - ack & stall: skid<=(rdata, `addr`); `addr`<=`addr`+4; go to FULL. Outputs hold.
  - !ack & !stall: `f_o_ce`<=0 (bubble).
  - !ack & stall: hold everything.
- DISCARD: any rdata is dropped.
  - redirect: `tgt`<=newest target (last wins).
  - ack: `addr`<=(redirect ? new target : `tgt`); go to FETCH.
  - `f_o_ce` stays 0 throughout.
- FULL: req=0.
  - redirect: drop skid; `addr`<=target; `f_o_ce`<=0; go to FETCH.
  - !stall: outputs<=skid; `f_o_ce`<=1; go to FETCH.
  - stall: hold.
- Redirect overrides stall in every state: `f_o_ce` is cleared even while stall=1.
- `addr`+4 is modulo 2^PCWIDTH, so 0xFFFFFFFC wraps to 0x0.
- No instruction is ever lost or duplicated except those squashed by a redirect.

## Timing
- Reset (async, f_rst=0) sets state=IDLE, `addr`=RESET_PC, `tgt`=0, skid=0, `f_o_instr`=0, `f_o_pc`=0, `f_o_ce`=0, `f_o_imem_req`=0. Outputs take these values immediately, independent of the clock.
- Reset asserted mid-request abandons the request. Memory must tolerate req dropping without ack.
- After release: edge 1 enters FETCH (req=1, addr=RESET_PC). With zero-wait ack, the first `f_o_ce`=1 follows at edge 2.
- Throughput: 1 instruction/cycle with continuous same-cycle ack and no stall. Each ack wait cycle inserts one bubble.
- Fetch-to-decode latency is 1 edge after the ack cycle.
- Redirect penalty with zero-wait memory: 1 bubble cycle, then target fetched; its instruction is valid 2 edges after the redirect edge.
- Redirect penalty with a pending request: bubbles last until the old ack arrives, plus the above.
- Stall→release: the skid instruction appears on the edge where stall is low; req resumes the same edge.

## Test plan
- Reset: hold f_rst=0 for 2 cycles with ack tied 1. All outputs 0 throughout. After release: req=0 for 1 cycle, then req=1 with addr=0x0.
- Streaming: memory always acks and returns 0x00430820, 0x00A62022, 0x01093824 at addresses 0x0/0x4/0x8. Required: `f_o_ce`=1 on consecutive cycles, `f_o_pc`=0x0, 0x4, 0x8 with the matching instructions.
- Stall: raise stall for 3 cycles while `f_o_pc`=0x8. Outputs hold 0x8; req drops after capturing 0xC. On release, 0xC is output next, then 0x10, with no gap or repeat.
- Redirect with zero-wait memory: redirect to 0x43 while fetching 0x10. Required: `f_o_ce`=0 for 1 cycle, then `f_o_pc`=0x40, 0x44; instruction 0x10 never appears.
- Redirect during a 3-cycle ack wait: redirect to 0x80 in cycle 1, then to 0x100 in cycle 2. `addr` stays at the old value until ack, and that data is dropped. Next req addr=0x100, `f_o_ce`=0 throughout.
- Wrap and mid-op reset: with RESET_PC=0xFFFFFFFC, outputs show pc 0xFFFFFFFC then 0x0. Asserting f_rst mid-stall with FULL clears req and ce immediately.
